state_hex_display: RTL and testbench

- Sequential, parametrised successor to the team's combinational state-to-hex decoder.
- Registers a one-hot controller state and looks up one 4-bit hex code per display digit from a parameter table.
- Adds illegal-state detection, per-digit blink masking with a programmable blink period, a display hold (freeze), and a state-change pulse.
- Sits between the controller FSM and the per-digit seven-segment decoders.

---
 rtl/state_hex_display.sv | 106 ++++++++++
 tb/tb_state_hex_display.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/state_hex_display.sv
// Registered one-hot state to per-digit hex code lookup, with illegal-state
// detection, per-digit blinking, display hold and a state-change pulse.
module state_hex_display #(
    parameter int                                 NUM_STATES = 7,
    parameter int                                 NUM_DIGITS = 6,
    parameter logic [NUM_STATES*NUM_DIGITS*4-1:0] MSG_TABLE  = {24'h666666, 24'h555555,
                                                                24'h444444, 24'h333333,
                                                                24'h222222, 24'h111111,
                                                                24'h000000},
    parameter logic [3:0]                         ERR_CODE   = 4'hE,
    parameter int                                 BLINK_DIV  = 25_000_000,
    parameter logic [NUM_DIGITS-1:0]              BLINK_MASK = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_STATES-1:0]   state_in,
    input  logic                    hold,
    input  logic                    blink_en,
    output logic [NUM_DIGITS*4-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   hex_blank,
    output logic                    illegal_state,
    output logic                    state_change
);
    localparam int               HEX_W    = NUM_DIGITS * 4;
    localparam int               CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [HEX_W-1:0] ERR_VEC  = {NUM_DIGITS{ERR_CODE}};

    function automatic logic is_one_hot(input logic [NUM_STATES-1:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (s[i]) ones++;
        end
        return (ones == 1);
    endfunction

    // OR-reduction over table rows: only meaningful for one-hot input, so no priority.
    function automatic logic [HEX_W-1:0] lookup_codes(input logic [NUM_STATES-1:0] s);
        logic [HEX_W-1:0] codes;
        codes = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (s[i]) codes = codes | MSG_TABLE[i*HEX_W +: HEX_W];
        end
        return codes;
    endfunction

    logic [HEX_W-1:0]      hex_d, hex_q;
    logic                  illegal_d, illegal_q;
    logic                  change_d, change_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  phase_d, phase_q;
    logic [NUM_DIGITS-1:0] blank_d, blank_q;
    logic                  legal;
    logic [HEX_W-1:0]      sample_codes;

    always_comb begin
        legal        = is_one_hot(state_in);
        sample_codes = legal ? lookup_codes(state_in) : ERR_VEC;

        hex_d     = hex_q;
        illegal_d = illegal_q;
        change_d  = 1'b0;
        if (!hold) begin
            hex_d     = sample_codes;
            illegal_d = !legal;
            change_d  = (sample_codes != hex_q);
        end

        // A new message restarts the blink cycle so it always appears visible first.
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (!blink_en || change_d) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = !phase_q;
        end

        blank_d = BLINK_MASK & {NUM_DIGITS{phase_d}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q     <= '0;
            illegal_q <= 1'b0;
            change_q  <= 1'b0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            blank_q   <= '0;
        end else begin
            hex_q     <= hex_d;
            illegal_q <= illegal_d;
            change_q  <= change_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            blank_q   <= blank_d;
        end
    end

    assign hex_out       = hex_q;
    assign hex_blank     = blank_q;
    assign illegal_state = illegal_q;
    assign state_change  = change_q;
endmodule

// File: tb/tb_state_hex_display.sv
// Self-checking bench for state_hex_display: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_state_hex_display;
    localparam int              NS   = 7;
    localparam int              ND   = 6;
    localparam int              BDIV = 4;
    localparam logic [ND-1:0]   MASK = 6'b110000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NS-1:0]   state_in = '0;
    logic            hold = 1'b0;
    logic            blink_en = 1'b0;
    logic [ND*4-1:0] hex_out;
    logic [ND-1:0]   hex_blank;
    logic            illegal_state;
    logic            state_change;

    int tests = 0;
    int errs  = 0;

    // Behavioural model state
    logic [ND*4-1:0] m_hex = '0;
    logic [ND-1:0]   m_blank = '0;
    logic            m_ill = 1'b0;
    logic            m_chg = 1'b0;
    int              m_age = 0;

    state_hex_display #(
        .NUM_STATES(NS), .NUM_DIGITS(ND), .BLINK_DIV(BDIV), .BLINK_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .state_in(state_in), .hold(hold), .blink_en(blink_en),
        .hex_out(hex_out), .hex_blank(hex_blank), .illegal_state(illegal_state),
        .state_change(state_change)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model over the edge, sample 1 time unit later.
    task automatic cycle(input logic r, input logic [NS-1:0] s, input logic h, input logic b);
        logic [ND*4-1:0] nv;
        int              idx;
        reset = r; state_in = s; hold = h; blink_en = b;
        @(posedge clk);
        if (r) begin
            m_hex = '0; m_ill = 1'b0; m_chg = 1'b0; m_age = 0;
        end else begin
            if ($countones(s) == 1) begin
                idx = $clog2(s);
                nv  = {ND{4'(idx)}};
            end else begin
                nv  = {ND{4'hE}};
            end
            if (!h) begin
                m_chg = (nv != m_hex);
                m_hex = nv;
                m_ill = ($countones(s) != 1);
            end else begin
                m_chg = 1'b0;
            end
            if (!b || m_chg) m_age = 0;
            else             m_age++;
        end
        m_blank = (((m_age / BDIV) % 2) == 1) ? MASK : '0;
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, '0, 1'b0, 1'b0);
        cycle(1'b1, 7'b0101010, 1'b1, 1'b1);
        tests++; if (hex_out !== 24'h000000) begin errs++; $display("FAIL reset_hex got %h exp %h", hex_out, 24'h0); end
        tests++; if (hex_blank !== 6'b0) begin errs++; $display("FAIL reset_blank got %b exp %b", hex_blank, 6'b0); end
        tests++; if (illegal_state !== 1'b0) begin errs++; $display("FAIL reset_illegal got %b exp 0", illegal_state); end
        tests++; if (state_change !== 1'b0) begin errs++; $display("FAIL reset_change got %b exp 0", state_change); end
    endtask

    task automatic test_legal();
        cycle(1'b0, 7'b0000100, 1'b0, 1'b0);
        tests++; if (hex_out !== 24'h222222) begin errs++; $display("FAIL legal_hex got %h exp %h", hex_out, 24'h222222); end
        tests++; if (illegal_state !== 1'b0) begin errs++; $display("FAIL legal_illegal got %b exp 0", illegal_state); end
        tests++; if (state_change !== 1'b1) begin errs++; $display("FAIL legal_pulse got %b exp 1", state_change); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 7'b0000100, 1'b0, 1'b0);
            tests++; if (state_change !== 1'b0 || hex_out !== 24'h222222) begin
                errs++; $display("FAIL legal_repeat chg=%b hex=%h exp chg=0 hex=222222", state_change, hex_out);
            end
        end
    endtask

    task automatic test_illegal();
        cycle(1'b0, 7'b0001100, 1'b0, 1'b0);
        tests++; if (hex_out !== 24'hEEEEEE || illegal_state !== 1'b1 || state_change !== 1'b1) begin
            errs++; $display("FAIL illegal_entry hex=%h ill=%b chg=%b exp EEEEEE 1 1", hex_out, illegal_state, state_change);
        end
        cycle(1'b0, 7'b0000000, 1'b0, 1'b0);
        tests++; if (hex_out !== 24'hEEEEEE || illegal_state !== 1'b1 || state_change !== 1'b0) begin
            errs++; $display("FAIL illegal_stay hex=%h ill=%b chg=%b exp EEEEEE 1 0", hex_out, illegal_state, state_change);
        end
        cycle(1'b0, 7'b0000001, 1'b0, 1'b0);
        tests++; if (hex_out !== 24'h000000 || illegal_state !== 1'b0 || state_change !== 1'b1) begin
            errs++; $display("FAIL illegal_exit hex=%h ill=%b chg=%b exp 000000 0 1", hex_out, illegal_state, state_change);
        end
    endtask

    task automatic test_blink();
        cycle(1'b0, 7'b0000100, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 7'b0000100, 1'b0, 1'b1);
            tests++; if (hex_blank !== ((((k / 4) % 2) == 1) ? 6'b110000 : 6'b000000) || hex_out !== 24'h222222) begin
                errs++; $display("FAIL blink_k%0d blank=%b hex=%h model_blank=%b", k, hex_blank, hex_out, m_blank);
            end
        end
    endtask

    task automatic test_change_restart();
        int n;
        n = 0;
        while (m_blank == '0 && n < 20) begin
            cycle(1'b0, 7'b0000100, 1'b0, 1'b1);
            n++;
        end
        tests++; if (hex_blank !== 6'b110000) begin errs++; $display("FAIL restart_phase1 got %b exp 110000 (waited %0d)", hex_blank, n); end
        cycle(1'b0, 7'b0000010, 1'b0, 1'b1);
        tests++; if (hex_blank !== 6'b0 || hex_out !== 24'h111111 || state_change !== 1'b1) begin
            errs++; $display("FAIL restart_change blank=%b hex=%h chg=%b exp 000000 111111 1", hex_blank, hex_out, state_change);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b0, 7'b0000010, 1'b0, 1'b1);
            tests++; if (hex_blank !== ((k == 4) ? 6'b110000 : 6'b000000)) begin
                errs++; $display("FAIL restart_k%0d blank=%b", k, hex_blank);
            end
        end
    endtask

    task automatic test_hold();
        logic [NS-1:0] seq [3];
        seq[0] = 7'b0000001; seq[1] = 7'b0000010; seq[2] = 7'b0100000;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, seq[i], 1'b1, 1'b1);
            tests++; if (hex_out !== 24'h111111 || state_change !== 1'b0 || hex_blank !== m_blank) begin
                errs++; $display("FAIL hold_%0d hex=%h chg=%b blank=%b exp 111111 0 %b", i, hex_out, state_change, hex_blank, m_blank);
            end
        end
        cycle(1'b0, 7'b0100000, 1'b0, 1'b1);
        tests++; if (hex_out !== 24'h555555 || state_change !== 1'b1) begin
            errs++; $display("FAIL hold_release hex=%h chg=%b exp 555555 1", hex_out, state_change);
        end
        cycle(1'b0, 7'b0100000, 1'b0, 1'b1);
        tests++; if (state_change !== 1'b0) begin errs++; $display("FAIL hold_single_pulse got %b exp 0", state_change); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 7'b0000011, 1'b0, 1'b1);
        cycle(1'b1, 7'b0000011, 1'b1, 1'b1);
        tests++; if (hex_out !== 24'h0 || hex_blank !== 6'b0 || illegal_state !== 1'b0 || state_change !== 1'b0) begin
            errs++; $display("FAIL midreset hex=%h blank=%b ill=%b chg=%b exp all 0", hex_out, hex_blank, illegal_state, state_change);
        end
        cycle(1'b0, 7'b0000011, 1'b0, 1'b1);
        tests++; if (hex_out !== 24'hEEEEEE || illegal_state !== 1'b1 || state_change !== 1'b1 || hex_blank !== 6'b0) begin
            errs++; $display("FAIL midreset_resume hex=%h ill=%b chg=%b blank=%b", hex_out, illegal_state, state_change, hex_blank);
        end
    endtask

    task automatic test_random();
        logic [NS-1:0] s;
        logic          r, h, b;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3, 0) != 0) s = NS'(1) << $urandom_range(NS - 1, 0);
            else                          s = NS'($urandom);
            r = ($urandom_range(49, 0) == 0);
            h = ($urandom_range(4, 0) == 0);
            b = ($urandom_range(9, 0) != 0);
            cycle(r, s, h, b);
            tests++; if (hex_out !== m_hex || hex_blank !== m_blank || illegal_state !== m_ill || state_change !== m_chg) begin
                errs++;
                $display("FAIL random_%0d got hex=%h blank=%b ill=%b chg=%b exp hex=%h blank=%b ill=%b chg=%b",
                         i, hex_out, hex_blank, illegal_state, state_change, m_hex, m_blank, m_ill, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_blink();
        test_change_restart();
        test_hold();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
